// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and FSM state type shared by the sequential ALU
package alu_pkg;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_NOT = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SRA = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_BEQ = 4'd6;
  localparam logic [3:0] OP_BNE = 4'd7;
  localparam logic [3:0] OP_SUB = 4'd8;
  localparam logic [3:0] OP_XOR = 4'd9;
  localparam logic [3:0] OP_SRL = 4'd10;
  localparam logic [3:0] OP_BLT = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;
  typedef enum logic [1:0] {IDLE, MUL_BUSY, DONE} state_e;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier, one partial product per cycle
// Ports: clk, rst_n; start_i loads a_i/b_i; done_o pulses on the cycle whose
// rising edge completes the product, with prod_o valid during that cycle.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);
  localparam int CW = $clog2(WIDTH);
  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] mcand_q, acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q;
  // The final partial product is folded in combinationally so the result is
  // ready on the same edge that retires the last multiplier bit.
  assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o = busy_q && cnt_q == '0;
  assign prod_o = acc_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= CW'(WIDTH - 1);
      mcand_q  <= {WIDTH'(0), a_i};
      mplier_q <= b_i;
      acc_q    <= '0;
    end else if (busy_q) begin
      busy_q   <= cnt_q != '0;
      cnt_q    <= cnt_q - CW'(1);
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_d;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered results and an iterative multiply
// Ports: in_valid/in_ready accept op,a,b; out_valid/out_ready hand off f with
// flags ovf (signed add/sub, unsigned mul overflow), take_branch, illegal.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             ovf,
  output logic             take_branch,
  output logic             illegal
);
  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
  state_e               state_q, state_d;
  logic [WIDTH-1:0]     f_q, f_d, res;
  logic                 ovf_q, ovf_d, br_q, br_d, ill_q, ill_d;
  logic                 r_ovf, r_br, r_ill, accept, mul_done;
  logic [SHW-1:0]       sh;
  logic [2*WIDTH-1:0]   prod;
  assign sh          = b[SHW-1:0];
  // Back-to-back issue: a new op may enter on the edge that retires the old result.
  assign in_ready    = rst_n && (state_q == IDLE || (state_q == DONE && out_ready));
  assign accept      = in_valid && in_ready;
  assign out_valid   = state_q == DONE;
  assign f           = f_q;
  assign ovf         = ovf_q;
  assign take_branch = br_q;
  assign illegal     = ill_q;
  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (accept && op == OP_MUL),
    .a_i     (a),
    .b_i     (b),
    .done_o  (mul_done),
    .prod_o  (prod)
  );
  always_comb begin
    res   = '0;
    r_ovf = 1'b0;
    r_br  = 1'b0;
    r_ill = 1'b0;
    case (op)
      OP_ADD: begin
        res   = a + b;
        r_ovf = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_SUB: begin
        res   = a - b;
        r_ovf = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_NOT: res = ~b;
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SRA: res = $signed(a) >>> sh;
      OP_SLL: res = a << sh;
      OP_SRL: res = a >> sh;
      OP_BEQ: r_br = a == b;
      OP_BNE: r_br = a != b;
      OP_BLT: r_br = $signed(a) < $signed(b);
      OP_MUL: ;
      default: r_ill = 1'b1;
    endcase
  end
  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    ovf_d   = ovf_q;
    br_d    = br_q;
    ill_d   = ill_q;
    if (accept) begin
      state_d = op == OP_MUL ? MUL_BUSY : DONE;
      if (op != OP_MUL) begin
        f_d   = res;
        ovf_d = r_ovf;
        br_d  = r_br;
        ill_d = r_ill;
      end
    end else if (state_q == MUL_BUSY && mul_done) begin
      state_d = DONE;
      f_d     = prod[WIDTH-1:0];
      ovf_d   = |prod[2*WIDTH-1:WIDTH];
      br_d    = 1'b0;
      ill_d   = 1'b0;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      f_q     <= '0;
      ovf_q   <= 1'b0;
      br_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      ovf_q   <= ovf_d;
      br_q    <= br_d;
      ill_q   <= ill_d;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at WIDTH=8
module tb_alu_seq;
  typedef struct {
    logic [3:0] op;
    logic [7:0] f;
    logic       ovf;
    logic       br;
    logic       ill;
    int         lat;
    int         acc;
  } exp_t;
  logic       clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic       ovf, take_branch, illegal;
  logic [3:0] op;
  logic [7:0] a, b, f;
  int         n_chk = 0, n_err = 0, cyc = 0;
  exp_t       sb[$];
  alu_seq #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .f           (f),
    .ovf         (ovf),
    .take_branch (take_branch),
    .illegal     (illegal)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                                 input int lat, input int acc);
    exp_t e;
    int sx = $signed(x);
    int sy = $signed(y);
    int ux = int'(x);
    int uy = int'(y);
    int sh = int'(y[2:0]);
    int s;
    e.op = o; e.f = 8'h00; e.ovf = 1'b0; e.br = 1'b0; e.ill = 1'b0; e.lat = lat; e.acc = acc;
    case (o)
      4'd0:  begin s = sx + sy; e.f = 8'(s); e.ovf = s > 127 || s < -128; end
      4'd8:  begin s = sx - sy; e.f = 8'(s); e.ovf = s > 127 || s < -128; end
      4'd1:  e.f = ~y;
      4'd2:  e.f = x & y;
      4'd3:  e.f = x | y;
      4'd9:  e.f = x ^ y;
      4'd4:  e.f = 8'(sx >>> sh);
      4'd5:  e.f = 8'(ux << sh);
      4'd10: e.f = 8'(ux >> sh);
      4'd6:  e.br = x == y;
      4'd7:  e.br = x != y;
      4'd11: e.br = sx < sy;
      4'd12: begin s = ux * uy; e.f = 8'(s); e.ovf = s > 255; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) chk("spurious_out", 1, 0);
        else begin
          e = sb.pop_front();
          chk($sformatf("op%0d_f", e.op), f, e.f);
          chk($sformatf("op%0d_ovf", e.op), ovf, e.ovf);
          chk($sformatf("op%0d_branch", e.op), take_branch, e.br);
          chk($sformatf("op%0d_illegal", e.op), illegal, e.ill);
          if (e.lat >= 0) chk($sformatf("op%0d_latency", e.op), cyc - e.acc, e.lat);
        end
      end
    end
  endtask
  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y, input int lat);
    int t = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    sb.push_back(model(o, x, y, lat, cyc));
    in_valid = 1'b0;
    op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [3:0] ro;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_f", f, 0);
    chk("rst_flags", {ovf, take_branch, illegal}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fork monitor(); join_none
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    @(posedge clk); #1;
    issue(4'd0, 8'h7F, 8'h01, 0);
    issue(4'd8, 8'h80, 8'h01, 0);
    issue(4'd4, 8'h90, 8'h03, 0);
    issue(4'd10, 8'h90, 8'h03, 0);
    issue(4'd4, 8'h90, 8'h00, 0);
    issue(4'd5, 8'h81, 8'h07, 0);
    issue(4'd1, 8'h00, 8'hA5, 0);
    issue(4'd3, 8'h0C, 8'h30, 0);
    issue(4'd12, 8'h10, 8'h11, 8);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mul_busy_in_ready", in_ready, 0);
      chk("mul_busy_out_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    issue(4'd12, 8'h0F, 8'h11, 8);
    issue(4'd12, 8'hFF, 8'hFF, 8);
    issue(4'd11, 8'hFF, 8'h01, 0);
    issue(4'd11, 8'h01, 8'hFF, 0);
    issue(4'd6, 8'h5A, 8'h5A, 0);
    issue(4'd7, 8'h5A, 8'h5A, 0);
    issue(4'd0, 8'h80, 8'h80, 0);
    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 15));
      issue(ro, 8'($urandom), 8'($urandom), ro == 4'd12 ? 8 : 0);
    end
    repeat (10) @(posedge clk);
    #1 out_ready = 1'b0;
    issue(4'd2, 8'hF0, 8'h3C, -1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_f", f, 8'h30);
      chk("hold_flags", {ovf, take_branch, illegal}, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(4'd9, 8'hF0, 8'h3C, 0);
    issue(4'd12, 8'h23, 8'h45, -1);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_f", f, 0);
    chk("arst_flags", {ovf, take_branch, illegal}, 0);
    chk("arst_in_ready", in_ready, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_stale_out_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    issue(4'd15, 8'h12, 8'h34, 0);
    issue(4'd13, 8'hFF, 8'hFF, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
